// File: rtl/pipe_ctrl_pkg.sv
// Shared types and limits for the pipeline stall/flush sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } pctrl_state_t;

  localparam int PCTRL_MAX_DEPTH = 16;
  localparam int PCTRL_STAT_W    = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Stream, stall and status signals between the controller and the pipeline/producer/consumer.
interface pipeline_stall_ctrl_if #(
  parameter int OCC_W  = 3,
  parameter int STAT_W = 16
);
  logic              up_valid;
  logic              up_ready;
  logic              dn_valid;
  logic              dn_ready;
  logic              ext_stall;
  logic              flush_req;
  logic              global_stall;
  logic              st0_valid;
  logic              st0_flush;
  logic              flush_busy;
  logic              flush_done;
  logic [OCC_W-1:0]  occupancy;
  logic [STAT_W-1:0] stall_cycles;
  logic              occ_err;

  modport master (
    input  up_valid, dn_valid, dn_ready, ext_stall, flush_req,
    output up_ready, global_stall, st0_valid, st0_flush, flush_busy,
           flush_done, occupancy, stall_cycles, occ_err
  );

  modport slave (
    output up_valid, dn_valid, dn_ready, ext_stall, flush_req,
    input  up_ready, global_stall, st0_valid, st0_flush, flush_busy,
           flush_done, occupancy, stall_cycles, occ_err
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Global-stall chain controller: stream adaptation at both ends, flush sequencing,
// occupancy tracking and stall statistics.
//   state | meaning
//   RUN   | normal streaming, upstream accepted when not stalled
//   FLUSH | st0_flush held until an unstalled cycle injects the token
//   DRAIN | token travelling down the chain, upstream blocked
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int OCC_W  = $clog2(DEPTH + 1),
  parameter int STAT_W = PCTRL_STAT_W
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_stall_ctrl_if.master bus
);
  localparam int               DRN_W    = $clog2(PCTRL_MAX_DEPTH);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);

  pctrl_state_t      state_q, state_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              stall, up_rdy, accept, exit_w, drain_end;
  logic [STAT_W-1:0] stall_cnt;

  assign stall     = bus.ext_stall | (bus.dn_valid & ~bus.dn_ready);
  assign up_rdy    = ~stall & (state_q == RUN);
  assign accept    = bus.up_valid & up_rdy;
  assign exit_w    = bus.dn_valid & bus.dn_ready;
  // Last unstalled DRAIN cycle: the token has left the final stage.
  assign drain_end = (state_q == DRAIN) & ~stall & (drain_q <= DRN_W'(1));

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (bus.flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (!stall) begin
          drain_d = DRN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          drain_d = '0;
          state_d = RUN;
        end else if (!stall) begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    err_d  = err_q;
    done_d = drain_end;
    if (accept && !exit_w) begin
      if (occ_q == OCC_MAX) err_d = 1'b1;
      else                  occ_d = occ_q + 1'b1;
    end else if (exit_w && !accept) begin
      if (occ_q == '0) err_d = 1'b1;
      else             occ_d = occ_q - 1'b1;
    end
    if (drain_end) occ_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      drain_q <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  pipe_sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  assign bus.global_stall = stall;
  assign bus.up_ready     = up_rdy;
  assign bus.st0_valid    = accept;
  assign bus.st0_flush    = (state_q == FLUSH);
  assign bus.flush_busy   = (state_q != RUN);
  assign bus.flush_done   = done_q;
  assign bus.occupancy    = occ_q;
  assign bus.stall_cycles = stall_cnt;
  assign bus.occ_err      = err_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with DEPTH=4 and a 4-stage valid shift chain.
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic force_en, force_v;
  logic [3:0] chain_v;
  int vecs = 0;
  int errs = 0;

  pipeline_stall_ctrl_if #(.OCC_W(3), .STAT_W(16)) bus ();

  pipeline_stall_ctrl #(.DEPTH(4), .OCC_W(3), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the stage chain: shifts on every unstalled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  chain_v <= '0;
    else if (!bus.global_stall) chain_v <= {chain_v[2:0], bus.st0_valid};
  end
  assign bus.dn_valid = force_en ? force_v : chain_v[3];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    force_en = 1'b0; force_v = 1'b0;
    bus.up_valid = 1'b0; bus.dn_ready = 1'b0;
    bus.ext_stall = 1'b0; bus.flush_req = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_stat", 32'(bus.stall_cycles), 0);
    chk("rst_busy", 32'(bus.flush_busy), 0);
    chk("rst_done", 32'(bus.flush_done), 0);
    chk("rst_err", 32'(bus.occ_err), 0);
    chk("rst_flush", 32'(bus.st0_flush), 0);
    chk("rst_st0v", 32'(bus.st0_valid), 0);
    chk("rst_gstall0", 32'(bus.global_stall), 0);
    bus.ext_stall = 1'b1; #1;
    chk("rst_gstall1", 32'(bus.global_stall), 1);
    bus.ext_stall = 1'b0;
    cyc(); reset = 1'b0;

    // 1: fill and drain
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.up_valid = 1'b1; bus.dn_ready = 1'b1; #2;
      chk("fill_occ", 32'(bus.occupancy), 32'(i));
      chk("fill_st0v", 32'(bus.st0_valid), 1);
      chk("fill_dnv", 32'(bus.dn_valid), 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.up_valid = 1'b0; #2;
      chk("drain_occ", 32'(bus.occupancy), 32'(4 - i));
      chk("drain_dnv", 32'(bus.dn_valid), 1);
    end
    cyc(); #2;
    chk("empty_occ", 32'(bus.occupancy), 0);
    chk("empty_dnv", 32'(bus.dn_valid), 0);

    // 2: backpressure for 5 cycles with two words in flight
    cyc(); bus.up_valid = 1'b1; #2;
    cyc(); #2;
    cyc(); bus.up_valid = 1'b0; #2;
    chk("bp_occ_pre", 32'(bus.occupancy), 2);
    cyc(); #2;
    chk("bp_dnv_pre", 32'(bus.dn_valid), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.dn_ready = 1'b0; bus.up_valid = 1'b1; #2;
      chk("bp_gstall", 32'(bus.global_stall), 1);
      chk("bp_upr", 32'(bus.up_ready), 0);
      chk("bp_st0v", 32'(bus.st0_valid), 0);
      chk("bp_occ", 32'(bus.occupancy), 2);
      chk("bp_stat", 32'(bus.stall_cycles), 32'(i));
    end
    cyc(); bus.dn_ready = 1'b1; bus.up_valid = 1'b0; #2;
    chk("bp_gstall_end", 32'(bus.global_stall), 0);
    chk("bp_upr_end", 32'(bus.up_ready), 1);
    chk("bp_stat_end", 32'(bus.stall_cycles), 5);
    cyc(); cyc(); #2;
    chk("bp_occ_end", 32'(bus.occupancy), 0);

    // 3: unstalled flush, request in cycle T
    cyc(); bus.flush_req = 1'b1; #2;
    chk("fl_req_flush", 32'(bus.st0_flush), 0);
    chk("fl_req_busy", 32'(bus.flush_busy), 0);
    cyc(); bus.flush_req = 1'b0; bus.up_valid = 1'b1; #2;
    chk("fl_t1_flush", 32'(bus.st0_flush), 1);
    chk("fl_t1_busy", 32'(bus.flush_busy), 1);
    chk("fl_t1_upr", 32'(bus.up_ready), 0);
    chk("fl_t1_st0v", 32'(bus.st0_valid), 0);
    for (int i = 2; i <= 4; i++) begin
      cyc(); #2;
      chk("fl_dr_flush", 32'(bus.st0_flush), 0);
      chk("fl_dr_busy", 32'(bus.flush_busy), 1);
      chk("fl_dr_done", 32'(bus.flush_done), 0);
      chk("fl_dr_upr", 32'(bus.up_ready), 0);
    end
    cyc(); bus.up_valid = 1'b0; #2;
    chk("fl_t5_done", 32'(bus.flush_done), 1);
    chk("fl_t5_busy", 32'(bus.flush_busy), 0);
    chk("fl_t5_upr", 32'(bus.up_ready), 1);
    chk("fl_t5_occ", 32'(bus.occupancy), 0);
    cyc(); #2;
    chk("fl_t6_done", 32'(bus.flush_done), 0);

    // 4: flush under a 3-cycle external stall, second request during DRAIN
    cyc(); bus.flush_req = 1'b1; #2;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.flush_req = 1'b0; bus.ext_stall = 1'b1; #2;
      chk("fs_flush_stl", 32'(bus.st0_flush), 1);
      chk("fs_gstall", 32'(bus.global_stall), 1);
    end
    cyc(); bus.ext_stall = 1'b0; #2;
    chk("fs_flush_4th", 32'(bus.st0_flush), 1);
    chk("fs_stat", 32'(bus.stall_cycles), 8);
    cyc(); #2;
    chk("fs_d1_flush", 32'(bus.st0_flush), 0);
    chk("fs_d1_busy", 32'(bus.flush_busy), 1);
    cyc(); bus.flush_req = 1'b1; #2;
    chk("fs_d2_done", 32'(bus.flush_done), 0);
    cyc(); bus.flush_req = 1'b0; #2;
    chk("fs_d3_done", 32'(bus.flush_done), 0);
    chk("fs_d3_busy", 32'(bus.flush_busy), 1);
    cyc(); #2;
    chk("fs_done", 32'(bus.flush_done), 1);
    chk("fs_done_busy", 32'(bus.flush_busy), 0);
    cyc(); #2;
    chk("fs_noqueue_flush", 32'(bus.st0_flush), 0);
    chk("fs_noqueue_busy", 32'(bus.flush_busy), 0);
    chk("fs_noqueue_done", 32'(bus.flush_done), 0);

    // 5: simultaneous accept and exit at occupancy 2, then forced underflow
    cyc(); bus.up_valid = 1'b1; #2;
    cyc(); #2;
    cyc(); bus.up_valid = 1'b0; #2;
    cyc(); #2;
    cyc(); bus.up_valid = 1'b1; #2;
    chk("sim_occ_pre", 32'(bus.occupancy), 2);
    chk("sim_st0v", 32'(bus.st0_valid), 1);
    chk("sim_dnv", 32'(bus.dn_valid), 1);
    cyc(); bus.up_valid = 1'b0; #2;
    chk("sim_occ_post", 32'(bus.occupancy), 2);
    cyc(); #2;
    chk("sim_occ_1", 32'(bus.occupancy), 1);
    cyc(); cyc(); cyc();
    force_en = 1'b1; force_v = 1'b1; #2;
    chk("uf_occ0", 32'(bus.occupancy), 0);
    chk("uf_err_pre", 32'(bus.occ_err), 0);
    cyc(); force_en = 1'b0; force_v = 1'b0; #2;
    chk("uf_err", 32'(bus.occ_err), 1);
    chk("uf_occ_hold", 32'(bus.occupancy), 0);
    cyc(); cyc(); #2;
    chk("uf_err_sticky", 32'(bus.occ_err), 1);

    // 6: reset in the middle of DRAIN
    cyc(); bus.flush_req = 1'b1; #2;
    cyc(); bus.flush_req = 1'b0; #2;
    chk("rd_flush", 32'(bus.st0_flush), 1);
    cyc(); #2;
    chk("rd_busy_pre", 32'(bus.flush_busy), 1);
    reset = 1'b1; #1;
    chk("rd_busy_rst", 32'(bus.flush_busy), 0);
    chk("rd_err_rst", 32'(bus.occ_err), 0);
    cyc(); reset = 1'b0; #2;
    chk("rd_upr", 32'(bus.up_ready), 1);
    chk("rd_busy", 32'(bus.flush_busy), 0);
    chk("rd_done", 32'(bus.flush_done), 0);
    cyc(); #2;
    chk("rd_done_next", 32'(bus.flush_done), 0);

    // 6b: saturation of the stall statistic from a preloaded value
    cyc(); bus.ext_stall = 1'b1;
    force dut.u_stall_cnt.cnt_q = 16'hFFF9;
    #1;
    release dut.u_stall_cnt.cnt_q;
    #1;
    chk("sat_preload", 32'(bus.stall_cycles), 32'h0000FFF9);
    for (int i = 1; i <= 9; i++) begin
      cyc(); #2;
      chk("sat_run", 32'(bus.stall_cycles), (i >= 6) ? 32'h0000FFFF : 32'(16'hFFF9 + i));
    end
    cyc(); bus.ext_stall = 1'b0; #2;
    chk("sat_hold", 32'(bus.stall_cycles), 32'h0000FFFF);
    cyc(); #2;
    chk("sat_hold_idle", 32'(bus.stall_cycles), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
